// File: rtl/smpl_mem_ctrl.sv
// Capture sequencer for the sample RAM: ring-buffer writes while armed,
// post-trigger counting, then newest-first readout over valid/ready.
//
// Ports: clk_i, rst_in (async, active low); arm_i / trg_i / stb_i /
// smpls_i capture controls; delay_cnt_i / read_cnt_i latched on arm;
// tx_data_o / tx_valid_o / tx_ready_i readout stream; busy_o;
// mem_en_o / mem_we_o / mem_addr_o / mem_d_o / mem_q_i RAM port
// (combinational read).
// Build option: define SMPL_CTRL_CLIP_EN to clip readout length to the
// number of samples stored since the last arm.

module smpl_mem_ctrl #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 3
) (
  input  logic             clk_i,
  input  logic             rst_in,
  input  logic             arm_i,
  input  logic             trg_i,
  input  logic             stb_i,
  input  logic [WIDTH-1:0] smpls_i,
  input  logic [15:0]      delay_cnt_i,
  input  logic [15:0]      read_cnt_i,
  output logic [WIDTH-1:0] tx_data_o,
  output logic             tx_valid_o,
  input  logic             tx_ready_i,
  output logic             busy_o,
  output logic             mem_en_o,
  output logic             mem_we_o,
  output logic [DEPTH-1:0] mem_addr_o,
  output logic [WIDTH-1:0] mem_d_o,
  input  logic [WIDTH-1:0] mem_q_i
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_POST,
    S_READ
  } state_t;

  state_t state_q, state_d;

  logic [DEPTH-1:0] wptr_q, rptr_q;
  logic [DEPTH-1:0] wptr_nx;
  logic [15:0]      delay_q, rdcnt_q;
  logic [15:0]      post_q, rem_q;
  logic [15:0]      post_inc;
  logic [15:0]      rd_len;
  logic             cap, wr, hs;
  logic             arm_ok, enter_rd;

  assign cap      = (state_q == S_ARMED) || (state_q == S_POST);
  assign wr       = cap && stb_i;
  assign hs       = (state_q == S_READ) && (rem_q != 16'd0)
                    && tx_ready_i;
  assign arm_ok   = (state_q == S_IDLE) && arm_i;
  assign wptr_nx  = wptr_q + DEPTH'(wr);
  assign post_inc = post_q + 16'd1;
  assign enter_rd = (state_q != S_READ) && (state_d == S_READ);

`ifdef SMPL_CTRL_CLIP_EN
  localparam int NENT = 2 ** DEPTH;
  localparam logic [DEPTH:0] FULL = NENT[DEPTH:0];

  logic [DEPTH:0] fill_q, fill_nx;

  // Fill must include a sample strobed in the cycle that enters READ.
  assign fill_nx = (wr && fill_q != FULL) ? fill_q + 1'b1 : fill_q;
  assign rd_len  = (rdcnt_q < 16'(fill_nx)) ? rdcnt_q
                                             : 16'(fill_nx);

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      fill_q <= '0;
    end else if (arm_ok) begin
      fill_q <= '0;
    end else begin
      fill_q <= fill_nx;
    end
  end
`else
  assign rd_len = rdcnt_q;
`endif

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (arm_i) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (trg_i) begin
          state_d = (delay_q == 16'd0) ? S_READ : S_POST;
        end
      end
      S_POST: begin
        if (stb_i && post_inc == delay_q) state_d = S_READ;
      end
      S_READ: begin
        if (rem_q == 16'd0) begin
          state_d = S_IDLE;
        end else if (hs && rem_q == 16'd1) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      delay_q <= '0;
      rdcnt_q <= '0;
      post_q  <= '0;
      rem_q   <= '0;
    end else begin
      if (arm_ok) begin
        delay_q <= delay_cnt_i;
        rdcnt_q <= read_cnt_i;
        post_q  <= '0;
      end
      if (wr) begin
        wptr_q <= wptr_nx;
      end
      // Trigger-cycle strobes are stored but not counted.
      if (state_q == S_POST && stb_i) begin
        post_q <= post_inc;
      end
      if (enter_rd) begin
        rptr_q <= wptr_nx - 1'b1;
        rem_q  <= rd_len;
      end else if (hs) begin
        rptr_q <= rptr_q - 1'b1;
        rem_q  <= rem_q - 16'd1;
      end
    end
  end

  always_comb begin
    mem_en_o   = 1'b0;
    mem_we_o   = 1'b0;
    mem_addr_o = '0;
    mem_d_o    = '0;
    tx_data_o  = '0;
    tx_valid_o = 1'b0;
    busy_o     = (state_q != S_IDLE);
    unique case (1'b1)
      cap: begin
        mem_en_o   = stb_i;
        mem_we_o   = stb_i;
        mem_addr_o = wptr_q;
        mem_d_o    = smpls_i;
      end
      (state_q == S_READ): begin
        mem_en_o   = 1'b1;
        mem_addr_o = rptr_q;
        tx_data_o  = mem_q_i;
        tx_valid_o = (rem_q != 16'd0);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_smpl_mem_ctrl.sv
// Directed bench for smpl_mem_ctrl (WIDTH=8, DEPTH=3) with a
// combinational-read RAM model attached to the RAM port.

module tb_smpl_mem_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_in;
  logic       arm_i, trg_i, stb_i;
  logic [7:0] smpls_i;
  logic [15:0] delay_cnt_i, read_cnt_i;
  logic [7:0] tx_data_o;
  logic       tx_valid_o, tx_ready_i, busy_o;
  logic       mem_en_o, mem_we_o;
  logic [2:0] mem_addr_o;
  logic [7:0] mem_d_o, mem_q_i;

  logic [7:0] ram [8];

  int nvec = 0;
  int nerr = 0;

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    if (mem_en_o && mem_we_o) ram[mem_addr_o] <= mem_d_o;
  end
  assign mem_q_i = ram[mem_addr_o];

  smpl_mem_ctrl #(.WIDTH(8), .DEPTH(3)) dut (
    .clk_i(clk_i), .rst_in(rst_in),
    .arm_i(arm_i), .trg_i(trg_i), .stb_i(stb_i),
    .smpls_i(smpls_i),
    .delay_cnt_i(delay_cnt_i), .read_cnt_i(read_cnt_i),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o),
    .tx_ready_i(tx_ready_i), .busy_o(busy_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_d_o(mem_d_o),
    .mem_q_i(mem_q_i)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic arm(input int d, input int r);
    arm_i = 1'b1;
    delay_cnt_i = 16'(d);
    read_cnt_i = 16'(r);
    tick();
    arm_i = 1'b0;
  endtask

  task automatic strobe(input int v, input logic t);
    stb_i = 1'b1;
    smpls_i = 8'(v);
    trg_i = t;
    tick();
    stb_i = 1'b0;
    trg_i = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    nvec++;
    if ({busy_o, tx_valid_o, mem_en_o, mem_we_o} !== 4'b0 ||
        tx_data_o !== 8'h0 || mem_addr_o !== 3'h0 ||
        mem_d_o !== 8'h0) begin
      nerr++;
      $display("FAIL reset_hold: got busy=%b v=%b en=%b we=%b want 0",
               busy_o, tx_valid_o, mem_en_o, mem_we_o);
    end
    tick();
    rst_in = 1'b1;
    tick();
    arm(5, 1);
    nvec++;
    if (busy_o !== 1'b1) begin
      nerr++;
      $display("FAIL arm_busy: got %b want 1", busy_o);
    end
    stb_i = 1'b1;
    smpls_i = 8'h77;
    #1;
    nvec++;
    if (mem_en_o !== 1'b1 || mem_we_o !== 1'b1) begin
      nerr++;
      $display("FAIL armed_we: got en=%b we=%b want 1 1",
               mem_en_o, mem_we_o);
    end
    #2;
    rst_in = 1'b0;
    #1;
    nvec++;
    if ({busy_o, tx_valid_o, mem_en_o, mem_we_o} !== 4'b0 ||
        mem_d_o !== 8'h0 || mem_addr_o !== 3'h0) begin
      nerr++;
      $display("FAIL async_reset: got busy=%b en=%b we=%b want 0",
               busy_o, mem_en_o, mem_we_o);
    end
    stb_i = 1'b0;
    tick();
    rst_in = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int e[$] = '{12, 11, 10, 9};
    arm(2, 4);
    for (int i = 1; i <= 12; i++) strobe(i, i == 10);
    foreach (e[i]) begin
      nvec++;
      if (tx_valid_o !== 1'b1 || tx_data_o !== 8'(e[i])) begin
        nerr++;
        $display("FAIL basic_rd%0d: got v=%b d=%0d want v=1 d=%0d",
                 i, tx_valid_o, tx_data_o, e[i]);
      end
      tick();
    end
    nvec++;
    if (busy_o !== 1'b0 || tx_valid_o !== 1'b0) begin
      nerr++;
      $display("FAIL basic_end: got busy=%b v=%b want 0 0",
               busy_o, tx_valid_o);
    end
  endtask

  task automatic test_zero_delay();
    int e[$] = '{5, 4, 3};
    arm(0, 3);
    for (int i = 1; i <= 5; i++) strobe(i, i == 5);
    foreach (e[i]) begin
      nvec++;
      if (tx_valid_o !== 1'b1 || tx_data_o !== 8'(e[i])) begin
        nerr++;
        $display("FAIL zdly_rd%0d: got v=%b d=%0d want v=1 d=%0d",
                 i, tx_valid_o, tx_data_o, e[i]);
      end
      tick();
    end
    nvec++;
    if (busy_o !== 1'b0) begin
      nerr++;
      $display("FAIL zdly_end: got busy=%b want 0", busy_o);
    end
    arm(0, 0);
    strobe(9, 1'b1);
    nvec++;
    if (busy_o !== 1'b1 || tx_valid_o !== 1'b0) begin
      nerr++;
      $display("FAIL rd0_entry: got busy=%b v=%b want 1 0",
               busy_o, tx_valid_o);
    end
    tick();
    nvec++;
    if (busy_o !== 1'b0) begin
      nerr++;
      $display("FAIL rd0_exit: got busy=%b want 0", busy_o);
    end
  endtask

  task automatic test_backpressure();
    int e[$] = '{5, 4, 3, 2};
    arm(1, 4);
    tx_ready_i = 1'b0;
    for (int i = 1; i <= 5; i++) strobe(i, i == 4);
    for (int i = 0; i < 3; i++) begin
      nvec++;
      if (tx_valid_o !== 1'b1 || tx_data_o !== 8'd5) begin
        nerr++;
        $display("FAIL bp_hold%0d: got v=%b d=%0d want v=1 d=5",
                 i, tx_valid_o, tx_data_o);
      end
      tick();
    end
    tx_ready_i = 1'b1;
    foreach (e[i]) begin
      nvec++;
      if (tx_valid_o !== 1'b1 || tx_data_o !== 8'(e[i])) begin
        nerr++;
        $display("FAIL bp_rd%0d: got v=%b d=%0d want v=1 d=%0d",
                 i, tx_valid_o, tx_data_o, e[i]);
      end
      tick();
    end
    nvec++;
    if (busy_o !== 1'b0) begin
      nerr++;
      $display("FAIL bp_end: got busy=%b want 0", busy_o);
    end
  endtask

  task automatic test_wrap();
    int e[$] = '{20, 19, 18, 17, 16, 15, 14, 13};
`ifdef SMPL_CTRL_CLIP_EN
    int f[$] = '{3, 2, 1};
`else
    int f[$] = '{20, 19, 18, 17, 16, 15, 14, 13, 20, 19};
`endif
    arm(0, 8);
    for (int i = 1; i <= 20; i++) strobe(i, i == 20);
    foreach (e[i]) begin
      nvec++;
      if (tx_valid_o !== 1'b1 || tx_data_o !== 8'(e[i])) begin
        nerr++;
        $display("FAIL wrap8_rd%0d: got v=%b d=%0d want v=1 d=%0d",
                 i, tx_valid_o, tx_data_o, e[i]);
      end
      tick();
    end
`ifdef SMPL_CTRL_CLIP_EN
    arm(0, 8);
    for (int i = 1; i <= 3; i++) strobe(i, i == 3);
`else
    arm(0, 10);
    trg_i = 1'b1;
    tick();
    trg_i = 1'b0;
`endif
    foreach (f[i]) begin
      nvec++;
      if (tx_valid_o !== 1'b1 || tx_data_o !== 8'(f[i])) begin
        nerr++;
        $display("FAIL wrap_rd%0d: got v=%b d=%0d want v=1 d=%0d",
                 i, tx_valid_o, tx_data_o, f[i]);
      end
      tick();
    end
    nvec++;
    if (busy_o !== 1'b0 || tx_valid_o !== 1'b0) begin
      nerr++;
      $display("FAIL wrap_end: got busy=%b v=%b want 0 0",
               busy_o, tx_valid_o);
    end
  endtask

  task automatic test_ignore_and_reset();
    arm(0, 3);
    tx_ready_i = 1'b0;
    for (int i = 31; i <= 33; i++) strobe(i, i == 33);
    arm_i = 1'b1;
    trg_i = 1'b1;
    stb_i = 1'b1;
    smpls_i = 8'hAA;
    #1;
    nvec++;
    if (mem_we_o !== 1'b0 || mem_en_o !== 1'b1 ||
        tx_valid_o !== 1'b1 || tx_data_o !== 8'd33) begin
      nerr++;
      $display("FAIL ign_we: got we=%b en=%b d=%0d want 0 1 33",
               mem_we_o, mem_en_o, tx_data_o);
    end
    @(posedge clk_i);
    #1;
    arm_i = 1'b0;
    trg_i = 1'b0;
    stb_i = 1'b0;
    nvec++;
    if (busy_o !== 1'b1 || tx_valid_o !== 1'b1 ||
        tx_data_o !== 8'd33) begin
      nerr++;
      $display("FAIL ign_state: got busy=%b v=%b d=%0d want 1 1 33",
               busy_o, tx_valid_o, tx_data_o);
    end
    tx_ready_i = 1'b1;
    tick();
    nvec++;
    if (tx_valid_o !== 1'b1 || tx_data_o !== 8'd32) begin
      nerr++;
      $display("FAIL ign_rd: got v=%b d=%0d want v=1 d=32",
               tx_valid_o, tx_data_o);
    end
    #3;
    rst_in = 1'b0;
    #1;
    nvec++;
    if (busy_o !== 1'b0 || tx_valid_o !== 1'b0 ||
        mem_en_o !== 1'b0 || tx_data_o !== 8'h0) begin
      nerr++;
      $display("FAIL rd_reset: got busy=%b v=%b en=%b want 0 0 0",
               busy_o, tx_valid_o, mem_en_o);
    end
    tick();
    rst_in = 1'b1;
    tick();
    arm(0, 2);
    strobe(41, 1'b0);
    strobe(42, 1'b1);
    nvec++;
    if (tx_valid_o !== 1'b1 || tx_data_o !== 8'd42) begin
      nerr++;
      $display("FAIL rearm_rd0: got v=%b d=%0d want v=1 d=42",
               tx_valid_o, tx_data_o);
    end
    tick();
    nvec++;
    if (tx_valid_o !== 1'b1 || tx_data_o !== 8'd41) begin
      nerr++;
      $display("FAIL rearm_rd1: got v=%b d=%0d want v=1 d=41",
               tx_valid_o, tx_data_o);
    end
    tick();
    nvec++;
    if (busy_o !== 1'b0) begin
      nerr++;
      $display("FAIL rearm_end: got busy=%b want 0", busy_o);
    end
  endtask

  initial begin
    rst_in = 1'b0;
    arm_i = 1'b0;
    trg_i = 1'b0;
    stb_i = 1'b0;
    smpls_i = '0;
    delay_cnt_i = '0;
    read_cnt_i = '0;
    tx_ready_i = 1'b1;
    test_reset();
    test_basic();
    test_zero_delay();
    test_backpressure();
    test_wrap();
    test_ignore_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/smpl_mem_ctrl.md
# smpl_mem_ctrl

Capture sequencer for the logic analyzer's distributed sample RAM. It writes strobed samples into the `lutram` ring buffer while armed and counts a programmable number of post-trigger samples. It then stops capture and streams a programmable number of stored samples, newest first, over a valid/ready interface. It sits between the sampler/trigger units and the transmitter, and is the sole master of the sample RAM port.

## Interface
Parameters:
- `WIDTH`, 32: sample width in bits.
- `DEPTH`, 3: RAM address width; the buffer holds 2**DEPTH entries.

Ports:
- `clk_i`  in  1  system clock.
- `rst_in`  in  1  asynchronous, active-low reset.
- `arm_i`  in  1  start-capture pulse; honoured in IDLE only.
- `trg_i`  in  1  trigger; honoured in ARMED only.
- `stb_i`  in  1  sample strobe.
- `smpls_i`  in  WIDTH  sample data, qualified by `stb_i`.
- `delay_cnt_i`  in  16  post-trigger sample count; latched on accepted arm.
- `read_cnt_i`  in  16  samples to transmit; latched on accepted arm.
- `tx_data_o`  out  WIDTH  readout data.
- `tx_valid_o`  out  1  readout data valid.
- `tx_ready_i`  in  1  transmitter accepts data.
- `busy_o`  out  1  high in any state other than IDLE.
- `mem_en_o`, `mem_we_o`  out  1  RAM enable and write enable.
- `mem_addr_o`  out  DEPTH  RAM address.
- `mem_d_o`  out  WIDTH  RAM write data.
- `mem_q_i`  in  WIDTH  RAM read data; the RAM read is combinational.

## Operation
The state machine has four states: IDLE, ARMED, POST and READ.

- **IDLE**
  - `arm_i` latches both counts, clears the post counter and fill counter, and moves to ARMED.
  - `trg_i` is ignored.
- **ARMED**
  - Each `stb_i` writes `smpls_i` at `wptr`, then `wptr` increments modulo 2**DEPTH.
  - `trg_i` with `delay_cnt`=0 moves to READ.
  - `trg_i` with `delay_cnt`>0 moves to POST.
  - A sample strobed in the trigger cycle is stored but does not count toward the delay.
- **POST**
  - Each `stb_i` writes a sample and increments the post counter.
  - The strobe that makes the post counter equal `delay_cnt` moves to READ.
  - `trg_i` and `arm_i` are ignored.
- **READ**
  - On entry, `rptr` = `wptr`-1 (modulo) and `remaining` = `read_cnt`.
  - `tx_valid_o` = (`remaining`≠0).
  - Each valid&ready handshake decrements both `rptr` (with wrap) and `remaining`.
  - The last handshake returns to IDLE. `read_cnt`=0 returns to IDLE the cycle after entry with no valid.
  - `stb_i`, `trg_i` and `arm_i` are ignored.

RAM port muxing is combinational from the state:
- ARMED/POST: `mem_en_o` = `mem_we_o` = `stb_i`, `mem_addr_o` = `wptr`, `mem_d_o` = `smpls_i`.
- READ: `mem_en_o`=1, `mem_we_o`=0, `mem_addr_o` = `rptr`.
- IDLE: all RAM outputs are 0.

Other rules:
- `tx_data_o` = `mem_q_i` in READ, else 0.
- `wptr` persists across captures; the sequencer never clears RAM contents.
- Counters are 16 bits and the comparison is exact.
- When `read_cnt` > 2**DEPTH, readout wraps and repeats entries, unless `SMPL_CTRL_CLIP_EN` is defined.

## Timing
- Reset, asynchronous: state IDLE; `wptr`, `rptr`, all counters and every output 0. RAM contents are untouched.
- Arm: ARMED and `busy_o` are seen the cycle after `arm_i`.
- Write: the sample is committed on the `stb_i` clock edge, with no added latency.
- Readout: the first `tx_valid_o` appears the cycle after the final post-trigger strobe, or after the trigger when `delay_cnt`=0.
- Read throughput: one sample per cycle while `tx_ready_i`=1.
- Backpressure: while valid and not ready, `tx_data_o` and `rptr` are held stable.
- Reset mid-operation: `tx_valid_o`, `busy_o` and the RAM enables fall immediately, asynchronously.
- Simultaneous `arm_i` & `trg_i` in IDLE: only the arm acts.

## Configuration
- `SMPL_CTRL_CLIP_EN` defined:
  - A fill counter increments on each stored sample, saturating at 2**DEPTH, and is cleared on arm.
  - On READ entry, `remaining` = min(`read_cnt`, fill), so stale or repeated entries are never sent.
- `SMPL_CTRL_CLIP_EN` undefined: there is no fill counter, and exactly `read_cnt` samples are sent with wrap.

## Test plan
All scenarios use WIDTH=8, DEPTH=3.
- **Reset:** assert `rst_in`=0 mid-clock → all outputs 0 at once, `busy_o`=0.
- **Basic capture:** arm with delay 2, read 4; strobe 1..10 with `trg_i` on sample 10, then strobe 11, 12 → `tx_data_o` 12, 11, 10, 9, then `busy_o`=0.
- **Zero delay:** arm with delay 0, read 3; trigger on sample 5 → next cycle valid, data 5, 4, 3.
- **Backpressure:** hold `tx_ready_i`=0 for 3 cycles during readout → `tx_valid_o`=1 and data held constant; no sample is skipped or duplicated.
- **Wrap:**
  - Strobe 20 samples, read 8 → 20..13.
  - Read 10 without the macro → 20..13, 20, 19.
  - With `SMPL_CTRL_CLIP_EN`, 3 samples since arm and read 8 → 3, 2, 1, then IDLE.
- **Ignored inputs and reset during READ:** `arm_i`, `trg_i` and `stb_i` during READ → no RAM write and no restart. Then `rst_in`=0 → IDLE, and a fresh arm works.
